decode_stage: RTL and testbench

Registered, flow-controlled successor to the combinational instruction decoder. It sits between the fetch unit and the execute stage. It accepts one 16-bit instruction word per handshake, classifies it into an operator group, and extracts its register and immediate fields. It holds the result in an output register until execute takes it. It also supports an optional PREFIX word that widens the immediate or relative address of the following instruction.

---
 rtl/decode_stage.sv | 183 ++++++++++++++++++
 tb/tb_decode_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered, flow-controlled instruction decode stage with an optional PREFIX word
// that widens the immediate/relative fields of the next instruction (DECODE_PREFIX_EN).
module decode_stage #(
    parameter int unsigned PFX_W = 8,
    parameter int unsigned PC_W  = 16,
`ifdef DECODE_PREFIX_EN
    localparam int unsigned VAL_W = 8 + PFX_W
`else
    localparam int unsigned VAL_W = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_word,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [3:0]        out_group,
    output logic [3:0]        out_operator,
    output logic [2:0]        out_rgv,
    output logic [2:0]        out_rg1,
    output logic [2:0]        out_rg2,
    output logic [VAL_W-1:0]  out_val,
    output logic [VAL_W-1:0]  out_rel,
    output logic              out_prefixed,
    output logic              pfx_pending
);

    typedef enum logic [3:0] {
        GROUP_CRVMATH       = 4'd0,
        GROUP_RJMP          = 4'd1,
        GROUP_CRRMATH       = 4'd2,
        GROUP_CRSMATH       = 4'd3,
        GROUP_WRRMATH       = 4'd4,
        GROUP_WRRMATH_MEM   = 4'd5,
        GROUP_WRSMATH       = 4'd6,
        GROUP_WRSMATH_STACK = 4'd7,
        GROUP_SFLAG         = 4'd8,
        GROUP_UFLAG         = 4'd9,
        GROUP_SPECIAL       = 4'd10,
        GROUP_PREFIX        = 4'd11,
        GROUP_ILLEGAL       = 4'd15
    } group_e;

    if (PFX_W < 1 || PFX_W > 11) begin : g_bad_pfx_w
        $error("decode_stage: PFX_W must be in 1..11");
    end

    function automatic group_e classify(input logic [15:0] w);
        group_e g;
        g = GROUP_ILLEGAL;
        casez (w[4:0])
            5'b0????: g = GROUP_CRVMATH;
            5'b10???: g = GROUP_RJMP;
            5'b11100: g = GROUP_CRRMATH;
            5'b11110: g = GROUP_CRSMATH;
            5'b11000: g = GROUP_SFLAG;
            5'b11001: g = GROUP_UFLAG;
            5'b11011: g = GROUP_SPECIAL;
`ifdef DECODE_PREFIX_EN
            5'b11010: g = GROUP_PREFIX;
`else
            5'b11010: g = GROUP_ILLEGAL;
`endif
            5'b11101: begin
                if (!w[15] || w[14:12] == 3'b011 || w[14:12] == 3'b111)
                    g = GROUP_WRRMATH;
                else
                    g = GROUP_WRRMATH_MEM;
            end
            5'b11111: g = (w[14:12] == 3'b111) ? GROUP_WRSMATH_STACK : GROUP_WRSMATH;
            default:  g = GROUP_ILLEGAL;
        endcase
        return g;
    endfunction

    group_e             grp;
    group_e             nxt_group;
    logic               load_out;
    logic               nxt_prefixed;
    logic [PC_W-1:0]    nxt_pc;
    logic [VAL_W-1:0]   nxt_val;
    logic [VAL_W-1:0]   nxt_rel;
    logic               accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef DECODE_PREFIX_EN
    logic               pfx_q;
    logic [PFX_W-1:0]   pfx_val_q;
    logic [PC_W-1:0]    pfx_pc_q;
    logic               latch_pfx;

    assign pfx_pending = pfx_q;
`else
    assign pfx_pending  = 1'b0;
    assign out_prefixed = 1'b0;
`endif

    always_comb begin
        grp          = classify(in_word);
        load_out     = 1'b1;
        nxt_group    = grp;
        nxt_pc       = in_pc;
        nxt_prefixed = 1'b0;
        nxt_val      = VAL_W'(in_word[11:4]);
        nxt_rel      = VAL_W'(signed'(in_word[7:0]));
`ifdef DECODE_PREFIX_EN
        latch_pfx = 1'b0;
        // A prefix only emits an output when it displaces an older pending prefix.
        if (grp == GROUP_PREFIX) begin
            latch_pfx = 1'b1;
            nxt_group = GROUP_ILLEGAL;
            load_out  = pfx_q;
        end
        if (pfx_q) begin
            nxt_pc       = pfx_pc_q;
            nxt_prefixed = 1'b1;
            nxt_val      = {pfx_val_q, in_word[11:4]};
            nxt_rel      = {pfx_val_q, in_word[7:0]};
            if (grp != GROUP_CRVMATH && grp != GROUP_RJMP)
                nxt_group = GROUP_ILLEGAL;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_group    <= GROUP_ILLEGAL;
            out_operator <= '0;
            out_rgv      <= '0;
            out_rg1      <= '0;
            out_rg2      <= '0;
            out_val      <= '0;
            out_rel      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept && load_out) begin
                out_valid    <= 1'b1;
                out_pc       <= nxt_pc;
                out_group    <= nxt_group;
                out_operator <= in_word[15:12];
                out_rgv      <= in_word[3:1];
                out_rg1      <= in_word[7:5];
                out_rg2      <= in_word[10:8];
                out_val      <= nxt_val;
                out_rel      <= nxt_rel;
            end
        end
    end

`ifdef DECODE_PREFIX_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pfx_q        <= 1'b0;
            pfx_val_q    <= '0;
            pfx_pc_q     <= '0;
            out_prefixed <= 1'b0;
        end else if (flush) begin
            pfx_q <= 1'b0;
        end else if (accept) begin
            pfx_q <= latch_pfx;
            if (latch_pfx) begin
                pfx_val_q <= in_word[4+PFX_W:5];
                pfx_pc_q  <= in_pc;
            end
            if (load_out)
                out_prefixed <= nxt_prefixed;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed, table-driven bench for decode_stage; prefix sequences run when
// DECODE_PREFIX_EN is defined, otherwise PREFIX words are checked as ILLEGAL.
module tb_decode_stage;

`ifdef DECODE_PREFIX_EN
    localparam int unsigned VAL_W = 16;
`else
    localparam int unsigned VAL_W = 8;
`endif

    localparam logic [3:0] G_CRVMATH = 4'd0,  G_RJMP = 4'd1,  G_CRRMATH = 4'd2,
                           G_CRSMATH = 4'd3,  G_WRRMATH = 4'd4, G_WRRMATH_MEM = 4'd5,
                           G_WRSMATH = 4'd6,  G_WRSMATH_STACK = 4'd7, G_SFLAG = 4'd8,
                           G_UFLAG = 4'd9,    G_SPECIAL = 4'd10, G_ILLEGAL = 4'd15;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0]       in_word, in_pc, out_pc;
    logic [3:0]        out_group, out_operator;
    logic [2:0]        out_rgv, out_rg1, out_rg2;
    logic [VAL_W-1:0]  out_val, out_rel;
    logic              out_prefixed, pfx_pending;

    int unsigned checks = 0;
    int unsigned passed = 0;

    always #5 clk = ~clk;

    decode_stage #(.PFX_W(8), .PC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_group(out_group), .out_operator(out_operator),
        .out_rgv(out_rgv), .out_rg1(out_rg1), .out_rg2(out_rg2),
        .out_val(out_val), .out_rel(out_rel),
        .out_prefixed(out_prefixed), .pfx_pending(pfx_pending)
    );

    typedef struct {
        logic [15:0] word;
        logic [3:0]  grp;
        logic [3:0]  op;
        logic [2:0]  rgv, rg1, rg2;
        logic [7:0]  val;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VAL_W-1:0] sext8(input logic [7:0] b);
        return VAL_W'(signed'(b));
    endfunction

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        tick();
    endtask

    task automatic send(input logic [15:0] w, input logic [15:0] pc);
        in_valid = 1'b1;
        in_word  = w;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_word = '0; in_pc = '0;

        //             word      group            op    rgv   rg1   rg2   val
        vecs.push_back('{16'h0001, G_CRVMATH,      4'h0, 3'd0, 3'd0, 3'd0, 8'h00});
        vecs.push_back('{16'h1E1C, G_CRRMATH,      4'h1, 3'd6, 3'd0, 3'd6, 8'hE1});
        vecs.push_back('{16'hA3F0, G_RJMP,         4'hA, 3'd0, 3'd7, 3'd3, 8'h3F});
        vecs.push_back('{16'h501E, G_CRSMATH,      4'h5, 3'd7, 3'd0, 3'd0, 8'h01});
        vecs.push_back('{16'h2118, G_SFLAG,        4'h2, 3'd4, 3'd0, 3'd1, 8'h11});
        vecs.push_back('{16'h0039, G_UFLAG,        4'h0, 3'd4, 3'd1, 3'd0, 8'h03});
        vecs.push_back('{16'hF0FB, G_SPECIAL,      4'hF, 3'd5, 3'd7, 3'd0, 8'h0F});
        vecs.push_back('{16'hB01D, G_WRRMATH,      4'hB, 3'd6, 3'd0, 3'd0, 8'h01});
        vecs.push_back('{16'hF01D, G_WRRMATH,      4'hF, 3'd6, 3'd0, 3'd0, 8'h01});
        vecs.push_back('{16'h9D3D, G_WRRMATH_MEM,  4'h9, 3'd6, 3'd1, 3'd5, 8'hD3});
        vecs.push_back('{16'h701D, G_WRRMATH,      4'h7, 3'd6, 3'd0, 3'd0, 8'h01});
        vecs.push_back('{16'h701F, G_WRSMATH_STACK,4'h7, 3'd7, 3'd0, 3'd0, 8'h01});
        vecs.push_back('{16'hE01F, G_WRSMATH,      4'hE, 3'd7, 3'd0, 3'd0, 8'h01});
        vecs.push_back('{16'h8085, G_CRVMATH,      4'h8, 3'd2, 3'd4, 3'd0, 8'h08});
`ifndef DECODE_PREFIX_EN
        vecs.push_back('{16'h1FDA, G_ILLEGAL,      4'h1, 3'd5, 3'd6, 3'd7, 8'hFD});
`endif

        // Reset state
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pfx_pending", 32'(pfx_pending), 32'd0);
        check("rst_out_prefixed", 32'(out_prefixed), 32'd0);
        check("rst_out_group", 32'(out_group), 32'(G_ILLEGAL));
        check("rst_out_val", 32'(out_val), 32'd0);
        check("rst_out_rel", 32'(out_rel), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Full-throughput stream of the decode table
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1;
            in_word  = vecs[i].word;
            in_pc    = 16'h0100 + 16'(i);
            tick();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_group", i), 32'(out_group), 32'(vecs[i].grp));
            check($sformatf("v%0d_op", i), 32'(out_operator), 32'(vecs[i].op));
            check($sformatf("v%0d_rgv", i), 32'(out_rgv), 32'(vecs[i].rgv));
            check($sformatf("v%0d_rg1", i), 32'(out_rg1), 32'(vecs[i].rg1));
            check($sformatf("v%0d_rg2", i), 32'(out_rg2), 32'(vecs[i].rg2));
            check($sformatf("v%0d_val", i), 32'(out_val), 32'(VAL_W'(vecs[i].val)));
            check($sformatf("v%0d_rel", i), 32'(out_rel), 32'(sext8(vecs[i].word[7:0])));
            check($sformatf("v%0d_pc", i), 32'(out_pc), 32'h0100 + i);
            check($sformatf("v%0d_prefixed", i), 32'(out_prefixed), 32'd0);
        end
        drain();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: one accept, three stalled cycles, one transfer on release
        out_ready = 1'b0;
        send(16'h0039, 16'h0200);
        check("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_word = 16'h2118; in_pc = 16'h0201;
        for (int unsigned c = 0; c < 3; c++) begin
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("bp%0d_group", c), 32'(out_group), 32'(G_UFLAG));
            check($sformatf("bp%0d_pc", c), 32'(out_pc), 32'h0200);
            check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(out_valid), 32'd0);
        tick();
        check("bp_no_extra", 32'(out_valid), 32'd0);

        // Flush drops a live output and the word offered in the same cycle
        send(16'h0001, 16'h0300);
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_word = 16'h0002; in_pc = 16'h0301; flush = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        tick();
        check("fl_dropped", 32'(out_valid), 32'd0);

`ifdef DECODE_PREFIX_EN
        // Prefix 0xFE widens an RJMP
        send(16'h1FDA, 16'h0040);
        check("p1_no_output", 32'(out_valid), 32'd0);
        check("p1_pending", 32'(pfx_pending), 32'd1);
        send(16'h0010, 16'h0041);
        check("p1_valid", 32'(out_valid), 32'd1);
        check("p1_group", 32'(out_group), 32'(G_RJMP));
        check("p1_rel", 32'(out_rel), 32'hFE10);
        check("p1_val", 32'(out_val), 32'hFE01);
        check("p1_pc", 32'(out_pc), 32'h0040);
        check("p1_prefixed", 32'(out_prefixed), 32'd1);
        check("p1_cleared", 32'(pfx_pending), 32'd0);

        // Prefix accepted while the previous output is consumed; then non-widenable CRRMATH
        send(16'h1FDA, 16'h0050);
        check("p2_valid_falls", 32'(out_valid), 32'd0);
        check("p2_pending", 32'(pfx_pending), 32'd1);
        send(16'h001C, 16'h0051);
        check("p2_group", 32'(out_group), 32'(G_ILLEGAL));
        check("p2_prefixed", 32'(out_prefixed), 32'd1);
        check("p2_pc", 32'(out_pc), 32'h0050);
        check("p2_op", 32'(out_operator), 32'h0);

        // Prefix, prefix, CRVMATH
        send(16'h1FDA, 16'h0060);
        send(16'h025A, 16'h0061);
        check("p3_first_valid", 32'(out_valid), 32'd1);
        check("p3_first_group", 32'(out_group), 32'(G_ILLEGAL));
        check("p3_first_pc", 32'(out_pc), 32'h0060);
        check("p3_still_pending", 32'(pfx_pending), 32'd1);
        send(16'h0040, 16'h0062);
        check("p3_group", 32'(out_group), 32'(G_CRVMATH));
        check("p3_val", 32'(out_val), 32'h1204);
        check("p3_rel", 32'(out_rel), 32'h1240);
        check("p3_pc", 32'(out_pc), 32'h0061);
        check("p3_prefixed", 32'(out_prefixed), 32'd1);

        // Flush cancels a pending prefix and the word offered alongside
        send(16'h1FDA, 16'h0070);
        check("p4_pending", 32'(pfx_pending), 32'd1);
        in_valid = 1'b1; in_word = 16'h0001; in_pc = 16'h0071; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("p4_pfx_cleared", 32'(pfx_pending), 32'd0);
        check("p4_valid", 32'(out_valid), 32'd0);
        send(16'h0010, 16'h0072);
        check("p4_unprefixed", 32'(out_prefixed), 32'd0);
        check("p4_pc", 32'(out_pc), 32'h0072);
        check("p4_rel", 32'(out_rel), 32'h0010);
`else
        // Without prefix support 0x1FDA is an ordinary ILLEGAL output
        send(16'h1FDA, 16'h0040);
        check("np_valid", 32'(out_valid), 32'd1);
        check("np_group", 32'(out_group), 32'(G_ILLEGAL));
        check("np_pending", 32'(pfx_pending), 32'd0);
        check("np_pc", 32'(out_pc), 32'h0040);
        send(16'h0010, 16'h0041);
        check("np_next_group", 32'(out_group), 32'(G_RJMP));
        check("np_next_prefixed", 32'(out_prefixed), 32'd0);
`endif

        // Reset overrides flush and acceptance
        send(16'h1E1C, 16'h0400);
        check("rr_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1; in_word = 16'h0001; in_pc = 16'h0401;
        tick();
        check("rr_valid", 32'(out_valid), 32'd0);
        check("rr_group", 32'(out_group), 32'(G_ILLEGAL));
        check("rr_pc", 32'(out_pc), 32'd0);
        check("rr_op", 32'(out_operator), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
